// File: rtl/imm_decode_stage_if.sv
// Handshake bundle between fetch, the immediate-decode stage and execute.
// The slave view belongs to the decode stage; the master view drives it.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [31:0]     out_instr;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_instr
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_instr
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV32I/RV64I immediate generator with valid/ready handshakes,
// optional one-entry skid buffer, flush and a saturating illegal-opcode count.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  illegal_cnt,
  imm_decode_stage_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  fmt_e            dec_fmt;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;

  logic            in_ready_int;
  logic            accept;
  logic            inc;

  logic            out_valid_q;
  logic [XLEN-1:0] out_imm_q;
  logic [2:0]      out_fmt_q;
  logic [31:0]     out_instr_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign func3  = instr[14:12];

  // Decode the incoming word into its format and a 32-bit immediate
  always_comb begin
    dec_fmt   = FMT_ILLEGAL;
    dec_imm32 = '0;
    case (opcode)
      7'b0010011: begin
        if (func3 == 3'b001 || func3 == 3'b101) begin
          dec_fmt   = FMT_SHAMT;
          // shamt bit 5 only exists on RV64
          dec_imm32 = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
        end else begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt   = FMT_R;
        dec_imm32 = '0;
      end
      default: begin
        dec_fmt   = FMT_ILLEGAL;
        dec_imm32 = '0;
      end
    endcase
  end

  // Every 32-bit immediate is already sign-correct, so widening is a plain
  // replication of bit 31 (zero for shamt, R and ILLEGAL).
  assign dec_imm = {{(XLEN-31){dec_imm32[31]}}, dec_imm32[30:0]};

  assign accept        = bus.in_valid && in_ready_int;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_fmt   = out_fmt_q;
  assign bus.out_instr = out_instr_q;

  generate
    if (SKID == 0) begin : g_noskid
      assign in_ready_int = !flush && (!out_valid_q || bus.out_ready);

      // Single output register, reloaded on every acceptance
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_imm_q   <= '0;
          out_fmt_q   <= '0;
          out_instr_q <= '0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (accept) begin
          out_valid_q <= 1'b1;
          out_imm_q   <= dec_imm;
          out_fmt_q   <= dec_fmt;
          out_instr_q <= instr;
        end else if (bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end else begin : g_skid
      logic            skid_valid;
      logic [XLEN-1:0] skid_imm;
      logic [2:0]      skid_fmt;
      logic [31:0]     skid_instr;
      logic            rdy_q;

      // in_ready comes straight from a flop, cut only by flush
      assign in_ready_int = rdy_q && !flush;

      // Output register backed by a one-entry skid; skid always drains first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_imm_q   <= '0;
          out_fmt_q   <= '0;
          out_instr_q <= '0;
          skid_valid  <= 1'b0;
          skid_imm    <= '0;
          skid_fmt    <= '0;
          skid_instr  <= '0;
          rdy_q       <= 1'b1;
        end else if (flush) begin
          out_valid_q <= 1'b0;
          skid_valid  <= 1'b0;
          rdy_q       <= 1'b1;
        end else if (!out_valid_q || bus.out_ready) begin
          if (skid_valid) begin
            out_valid_q <= 1'b1;
            out_imm_q   <= skid_imm;
            out_fmt_q   <= skid_fmt;
            out_instr_q <= skid_instr;
            skid_valid  <= 1'b0;
            rdy_q       <= 1'b1;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            out_imm_q   <= dec_imm;
            out_fmt_q   <= dec_fmt;
            out_instr_q <= instr;
          end else begin
            out_valid_q <= 1'b0;
          end
        end else if (accept) begin
          skid_valid <= 1'b1;
          skid_imm   <= dec_imm;
          skid_fmt   <= dec_fmt;
          skid_instr <= instr;
          rdy_q      <= 1'b0;
        end
      end
    end
  endgenerate

  assign inc = accept && (dec_fmt == FMT_ILLEGAL);

  // Saturating count of accepted illegal opcodes; clear wins over history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      illegal_cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && illegal_cnt != {CNT_W{1'b1}}) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule
